// File: rtl/reg_file_param.sv
`default_nettype none
// ============================================================================
// Module   : reg_file_param
// Purpose  : Parametrised general-purpose register bank. One write port with
//            per-byte strobes, two combinational read ports, an optional
//            hardwired-zero register 0 and optional write-to-read bypass.
// Ports    : clk     - clock, all state updates on the rising edge
//            clr     - synchronous active-high clear of every register
//            we      - write enable
//            waddr   - write address
//            wdata   - write data
//            wstrb   - byte write strobes, bit i enables wdata[8i+7:8i]
//            raddr_a - read port A address
//            rdata_a - read port A data (combinational)
//            raddr_b - read port B address
//            rdata_b - read port B data (combinational)
// Revision : 1.0 - initial release
// ============================================================================
module reg_file_param #(
    parameter int WIDTH    = 16,
    parameter int NUM_REGS = 8,
    parameter int ADDR_W   = 3,
    parameter int ZERO_REG = 1,
    parameter int BYPASS   = 0
) (
    input  logic                 clk,
    input  logic                 clr,
    input  logic                 we,
    input  logic [ADDR_W-1:0]    waddr,
    input  logic [WIDTH-1:0]     wdata,
    input  logic [WIDTH/8-1:0]   wstrb,
    input  logic [ADDR_W-1:0]    raddr_a,
    output logic [WIDTH-1:0]     rdata_a,
    input  logic [ADDR_W-1:0]    raddr_b,
    output logic [WIDTH-1:0]     rdata_b
);

    localparam int c_nbytes = WIDTH / 8;

    // Current contents of every register (register 0 is constant zero when
    // ZERO_REG is set).
    logic [WIDTH-1:0] w_regs [NUM_REGS];

    logic [WIDTH-1:0] w_stored_a;
    logic [WIDTH-1:0] w_stored_b;
    logic [WIDTH-1:0] w_stored_w;
    logic             w_in_range;
    logic             w_wr_en;
    logic [WIDTH-1:0] w_merged;

    // Address decode by comparison against every implemented index, so an
    // address at or beyond NUM_REGS simply matches nothing and reads zero.
    always_comb begin
        w_stored_a = '0;
        w_stored_b = '0;
        w_stored_w = '0;
        w_in_range = 1'b0;
        for (int i = 0; i < NUM_REGS; i++) begin
            if (raddr_a == ADDR_W'(i)) begin
                w_stored_a = w_regs[i];
            end
            if (raddr_b == ADDR_W'(i)) begin
                w_stored_b = w_regs[i];
            end
            if (waddr == ADDR_W'(i)) begin
                w_stored_w = w_regs[i];
                w_in_range = 1'b1;
            end
        end
    end

    // A write takes effect only when it targets a real, writable register
    // and is not overridden by clr. The same qualifier gates the bypass.
    assign w_wr_en = we && !clr && w_in_range &&
                     !((ZERO_REG != 0) && (waddr == '0));

    // Value the target register holds after the edge: strobed bytes from
    // wdata, everything else from the current contents.
    always_comb begin
        w_merged = w_stored_w;
        for (int b = 0; b < c_nbytes; b++) begin
            if (wstrb[b]) begin
                w_merged[8*b +: 8] = wdata[8*b +: 8];
            end
        end
    end

    for (genvar gi = 0; gi < NUM_REGS; gi++) begin : g_reg
        if ((ZERO_REG != 0) && (gi == 0)) begin : g_zero
            assign w_regs[gi] = '0;
        end else begin : g_store
            logic [WIDTH-1:0] r_q;
            logic             w_sel;

            assign w_sel = w_wr_en && (waddr == ADDR_W'(gi));

            always_ff @(posedge clk) begin
                if (clr) begin
                    r_q <= '0;
                end else if (w_sel) begin
                    r_q <= w_merged;
                end
            end

            assign w_regs[gi] = r_q;
        end
    end

    // Bypass forwards the merged value only for a qualified write; a write to
    // the zero register or an out-of-range address is never forwarded.
    assign rdata_a = ((BYPASS != 0) && w_wr_en && (raddr_a == waddr)) ? w_merged : w_stored_a;
    assign rdata_b = ((BYPASS != 0) && w_wr_en && (raddr_b == waddr)) ? w_merged : w_stored_b;

endmodule
`default_nettype wire

// File: tb/tb_reg_file_param.sv
`default_nettype none
// ============================================================================
// Module   : tb_reg_file_param
// Purpose  : Self-checking bench for reg_file_param. Two instances share the
//            stimulus: u_dut0 (8 regs, zero register, no bypass) and u_dut1
//            (6 regs, ordinary register 0, bypass). A per-instance array
//            model supplies expected read data.
// Revision : 1.0 - initial release
// ============================================================================
module tb_reg_file_param;

    logic        clk = 1'b0;
    logic        clr;
    logic        we;
    logic [2:0]  waddr;
    logic [15:0] wdata;
    logic [1:0]  wstrb;
    logic [2:0]  raddr_a;
    logic [2:0]  raddr_b;
    logic [15:0] rd_a0, rd_b0, rd_a1, rd_b1;

    always #5 clk = ~clk;

    reg_file_param #(
        .WIDTH(16), .NUM_REGS(8), .ADDR_W(3), .ZERO_REG(1), .BYPASS(0)
    ) u_dut0 (
        .clk(clk), .clr(clr), .we(we), .waddr(waddr), .wdata(wdata),
        .wstrb(wstrb), .raddr_a(raddr_a), .rdata_a(rd_a0),
        .raddr_b(raddr_b), .rdata_b(rd_b0)
    );

    reg_file_param #(
        .WIDTH(16), .NUM_REGS(6), .ADDR_W(3), .ZERO_REG(0), .BYPASS(1)
    ) u_dut1 (
        .clk(clk), .clr(clr), .we(we), .waddr(waddr), .wdata(wdata),
        .wstrb(wstrb), .raddr_a(raddr_a), .rdata_a(rd_a1),
        .raddr_b(raddr_b), .rdata_b(rd_b1)
    );

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: plain arrays, one row per instance configuration.
    logic [15:0] mem [2][8];
    int          cfg_num [2] = '{8, 6};
    bit          cfg_zr  [2] = '{1'b1, 1'b0};
    bit          cfg_byp [2] = '{1'b0, 1'b1};

    task automatic chk_value(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    function automatic logic [15:0] merge(input logic [15:0] old);
        logic [15:0] v;
        v = old;
        if (wstrb[0]) v[7:0]  = wdata[7:0];
        if (wstrb[1]) v[15:8] = wdata[15:8];
        return v;
    endfunction

    function automatic bit writable(input int c, input int a);
        return (a < cfg_num[c]) && !(cfg_zr[c] && a == 0);
    endfunction

    function automatic logic [15:0] exp_rd(input int c, input int a);
        logic [15:0] v;
        if (!writable(c, a)) return 16'h0000;
        v = mem[c][a];
        if (cfg_byp[c] && we && !clr && a == int'(waddr)) v = merge(v);
        return v;
    endfunction

    task automatic model_commit();
        for (int c = 0; c < 2; c++) begin
            if (clr) begin
                for (int a = 0; a < 8; a++) mem[c][a] = 16'h0000;
            end else if (we && writable(c, int'(waddr))) begin
                mem[c][waddr] = merge(mem[c][waddr]);
            end
        end
    endtask

    task automatic drive(input logic c, input logic w, input logic [2:0] wa,
                         input logic [15:0] wd, input logic [1:0] ws,
                         input logic [2:0] ra, input logic [2:0] rb);
        clr = c; we = w; waddr = wa; wdata = wd; wstrb = ws;
        raddr_a = ra; raddr_b = rb;
    endtask

    // Inputs are applied 1 ns after a rising edge; outputs are compared
    // mid-cycle, then the model advances past the next rising edge.
    task automatic cycle(input bit do_chk);
        #2;
        if (do_chk) begin
            chk_value("dut0_rdata_a", rd_a0, exp_rd(0, int'(raddr_a)));
            chk_value("dut0_rdata_b", rd_b0, exp_rd(0, int'(raddr_b)));
            chk_value("dut1_rdata_a", rd_a1, exp_rd(1, int'(raddr_a)));
            chk_value("dut1_rdata_b", rd_b1, exp_rd(1, int'(raddr_b)));
        end
        @(posedge clk);
        #1;
        model_commit();
    endtask

    initial begin
        drive(1'b1, 1'b0, 3'd0, 16'h0, 2'b00, 3'd0, 3'd0);
        @(posedge clk);
        #1;
        // Registers are undefined until the first clr: clear without checking.
        cycle(1'b0);

        // Reset after a write: all addresses read zero on both ports.
        drive(1'b0, 1'b1, 3'd3, 16'hABCD, 2'b11, 3'd3, 3'd3);
        cycle(1'b1);
        drive(1'b1, 1'b0, 3'd0, 16'h0, 2'b00, 3'd3, 3'd3);
        cycle(1'b1);
        for (int a = 0; a < 8; a++) begin
            drive(1'b0, 1'b0, 3'd0, 16'h0, 2'b00, 3'(a), 3'(a));
            #2;
            chk_value("reset_dut0_a", rd_a0, 16'h0000);
            chk_value("reset_dut0_b", rd_b0, 16'h0000);
            chk_value("reset_dut1_a", rd_a1, 16'h0000);
            chk_value("reset_dut1_b", rd_b1, 16'h0000);
            cycle(1'b1);
        end

        // Write/readback with write-cycle visibility.
        drive(1'b0, 1'b1, 3'd5, 16'h1234, 2'b11, 3'd5, 3'd5);
        #2;
        chk_value("wr_cycle_nobyp_a", rd_a0, 16'h0000);
        chk_value("wr_cycle_nobyp_b", rd_b0, 16'h0000);
        chk_value("wr_cycle_byp_a", rd_a1, 16'h1234);
        chk_value("wr_cycle_byp_b", rd_b1, 16'h1234);
        cycle(1'b1);
        drive(1'b0, 1'b0, 3'd0, 16'h0, 2'b00, 3'd5, 3'd5);
        #2;
        chk_value("readback_a", rd_a0, 16'h1234);
        chk_value("readback_b", rd_b0, 16'h1234);
        cycle(1'b1);

        // Byte strobes on r2.
        drive(1'b0, 1'b1, 3'd2, 16'hFFFF, 2'b11, 3'd2, 3'd2);
        cycle(1'b1);
        drive(1'b0, 1'b1, 3'd2, 16'h00AA, 2'b01, 3'd2, 3'd2);
        cycle(1'b1);
        drive(1'b0, 1'b0, 3'd0, 16'h0, 2'b00, 3'd2, 3'd2);
        #2;
        chk_value("strb_low", rd_a0, 16'hFFAA);
        cycle(1'b1);
        drive(1'b0, 1'b1, 3'd2, 16'h5500, 2'b10, 3'd2, 3'd2);
        cycle(1'b1);
        drive(1'b0, 1'b1, 3'd2, 16'h1234, 2'b00, 3'd2, 3'd2);
        cycle(1'b1);
        drive(1'b0, 1'b0, 3'd0, 16'h0, 2'b00, 3'd2, 3'd2);
        #2;
        chk_value("strb_none_dut0", rd_a0, 16'h55AA);
        chk_value("strb_none_dut1", rd_b1, 16'h55AA);
        cycle(1'b1);

        // Zero register versus ordinary register 0.
        drive(1'b0, 1'b1, 3'd0, 16'hBEEF, 2'b11, 3'd1, 3'd1);
        cycle(1'b1);
        drive(1'b0, 1'b0, 3'd0, 16'h0, 2'b00, 3'd0, 3'd0);
        #2;
        chk_value("zero_reg", rd_a0, 16'h0000);
        chk_value("plain_reg0", rd_a1, 16'hBEEF);
        cycle(1'b1);

        // clr beats we on the same edge.
        drive(1'b1, 1'b1, 3'd4, 16'h7777, 2'b11, 3'd4, 3'd4);
        #2;
        chk_value("clr_no_bypass", rd_a1, 16'h0000);
        cycle(1'b1);
        drive(1'b0, 1'b0, 3'd0, 16'h0, 2'b00, 3'd4, 3'd4);
        #2;
        chk_value("clr_we_dut0", rd_a0, 16'h0000);
        chk_value("clr_we_dut1", rd_b1, 16'h0000);
        cycle(1'b1);

        // Partial-strobe bypass on r4 of the bypass instance.
        drive(1'b0, 1'b1, 3'd4, 16'h1100, 2'b11, 3'd0, 3'd0);
        cycle(1'b1);
        drive(1'b0, 1'b1, 3'd4, 16'h0022, 2'b01, 3'd4, 3'd4);
        #2;
        chk_value("bypass_merge_a", rd_a1, 16'h1122);
        chk_value("bypass_merge_b", rd_b1, 16'h1122);
        chk_value("nobypass_old", rd_a0, 16'h1100);
        cycle(1'b1);
        drive(1'b0, 1'b0, 3'd0, 16'h0, 2'b00, 3'd4, 3'd4);
        #2;
        chk_value("bypass_after", rd_a1, 16'h1122);
        cycle(1'b1);

        // Address 7 is out of range on the 6-register instance.
        drive(1'b0, 1'b1, 3'd7, 16'hA5A5, 2'b11, 3'd7, 3'd6);
        #2;
        chk_value("oor_no_bypass_a", rd_a1, 16'h0000);
        chk_value("oor_no_bypass_b", rd_b1, 16'h0000);
        cycle(1'b1);
        drive(1'b0, 1'b0, 3'd0, 16'h0, 2'b00, 3'd7, 3'd7);
        #2;
        chk_value("oor_read", rd_a1, 16'h0000);
        chk_value("in_range_r7", rd_a0, 16'hA5A5);
        cycle(1'b1);

        // Randomized traffic against the model.
        for (int n = 0; n < 400; n++) begin
            drive(($urandom_range(0, 15) == 0), ($urandom_range(0, 3) != 0),
                  3'($urandom_range(0, 7)), 16'($urandom),
                  2'($urandom_range(0, 3)),
                  3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)));
            cycle(1'b1);
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
